reorder_buffer: RTL and testbench

- Circular in-order retirement buffer: allocates tags to dispatched instructions, captures results broadcast on the CDB, and commits one instruction per cycle from the head.
- Downstream of the dispatcher, upstream of the register file. Drives the RF update port, the RF flush signal and the memory-store release.
- Provides operand bypass lookups so the dispatcher can read results that are complete but not yet committed.

---
 rtl/reorder_buffer_pkg.sv | 39 +++
 rtl/rob_entry_array.sv | 79 +++++++
 rtl/reorder_buffer.sv | 155 +++++++++++++++
 tb/tb_reorder_buffer.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared ROB definitions: entry type encodings, tag widths and entry payload layouts.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package reorder_buffer_pkg;

    // Default tag width, shared with the register file, reservation stations and load/store buffer.
    localparam int ROB_WIDTH_DEFAULT = 3;

    // Tag value with the extra top bit set: operand has no producer in flight.
    localparam logic [ROB_WIDTH_DEFAULT:0] NON_DEP = {1'b1, {ROB_WIDTH_DEFAULT{1'b0}}};

    typedef enum logic [1:0] {
        TYPE_REG    = 2'b00,
        TYPE_BRANCH = 2'b01,
        TYPE_STORE  = 2'b10,
        TYPE_EXIT   = 2'b11
    } rob_type_e;

    // Fields captured when the dispatcher allocates an entry.
    typedef struct packed {
        rob_type_e   typ;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        pred_taken;
    } rob_info_t;

    // Fields captured from the CDB when the result arrives.
    typedef struct packed {
        logic [31:0] value;
        logic        taken;
        logic [31:0] target;
    } rob_result_t;

    // Fetch redirect after a mispredicted branch retires.
    function automatic logic [31:0] redirect_pc(input rob_info_t info, input rob_result_t res);
        return res.taken ? res.target : info.pc + 32'd4;
    endfunction

endpackage

// File: rtl/rob_entry_array.sv
// ROB entry storage: busy/ready flags plus allocation and result payloads, three read ports.
// Latency: writes visible the cycle after the edge; reads are combinational.
// Backpressure: none; the caller qualifies every write strobe.
module rob_entry_array
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_WIDTH = ROB_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc_we,
    input  logic [ROB_WIDTH-1:0] alloc_idx,
    input  rob_info_t            alloc_info,
    input  logic                 cdb_we,
    input  logic [ROB_WIDTH-1:0] cdb_idx,
    input  rob_result_t          cdb_res,
    input  logic                 commit_clr,
    input  logic [ROB_WIDTH-1:0] commit_idx,
    input  logic                 clear_all,
    input  logic [ROB_WIDTH-1:0] head_idx,
    output logic                 head_ready,
    output rob_info_t            head_info,
    output rob_result_t          head_res,
    input  logic [ROB_WIDTH-1:0] q1_idx,
    output logic                 q1_rdy,
    output logic [31:0]          q1_val,
    input  logic [ROB_WIDTH-1:0] q2_idx,
    output logic                 q2_rdy,
    output logic [31:0]          q2_val
);
    localparam int ROB_SIZE = 1 << ROB_WIDTH;

    logic [ROB_SIZE-1:0] busy;
    logic [ROB_SIZE-1:0] ready;
    rob_info_t           info [ROB_SIZE];
    rob_result_t         res  [ROB_SIZE];

    // Flag update: CDB marks busy entries ready, commit frees the head, allocation claims the tail.
    // STORE and EXIT carry no result, so they are complete as soon as they are allocated.
    always_ff @(posedge clk) begin
        if (rst || clear_all) begin
            busy  <= '0;
            ready <= '0;
        end else begin
            if (cdb_we && busy[cdb_idx]) begin
                ready[cdb_idx] <= 1'b1;
            end
            if (commit_clr) begin
                busy[commit_idx]  <= 1'b0;
                ready[commit_idx] <= 1'b0;
            end
            if (alloc_we) begin
                busy[alloc_idx]  <= 1'b1;
                ready[alloc_idx] <= (alloc_info.typ == TYPE_STORE) || (alloc_info.typ == TYPE_EXIT);
            end
        end
    end

    // Payload capture; contents of non-busy entries are don't-care, so no reset is needed.
    always_ff @(posedge clk) begin
        if (alloc_we) begin
            info[alloc_idx] <= alloc_info;
        end
        if (cdb_we && busy[cdb_idx]) begin
            res[cdb_idx] <= cdb_res;
        end
    end

    // Ready is only ever set on busy entries and is cleared with busy, so it alone qualifies the head.
    assign head_ready = ready[head_idx];
    assign head_info  = info[head_idx];
    assign head_res   = res[head_idx];

    assign q1_rdy = busy[q1_idx] && ready[q1_idx];
    assign q1_val = res[q1_idx].value;
    assign q2_rdy = busy[q2_idx] && ready[q2_idx];
    assign q2_val = res[q2_idx].value;

endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order retirement buffer: tag allocation, CDB capture, one commit per cycle from head.
// Latency: CDB result commits no earlier than two edges later; commit side effects are registered pulses.
// Backpressure: full refuses allocation; flush_out and rdy_in low freeze allocation, rdy_in low freezes all.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_WIDTH = ROB_WIDTH_DEFAULT
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 alloc_en,
    input  logic [1:0]           alloc_type,
    input  logic [4:0]           alloc_rd,
    input  logic [31:0]          alloc_pc,
    input  logic                 alloc_pred_taken,
    output logic [ROB_WIDTH-1:0] alloc_index,
    output logic                 full,
    input  logic                 cdb_en,
    input  logic [ROB_WIDTH-1:0] cdb_index,
    input  logic [31:0]          cdb_value,
    input  logic                 cdb_taken,
    input  logic [31:0]          cdb_target,
    input  logic [ROB_WIDTH-1:0] query_idx1,
    input  logic [ROB_WIDTH-1:0] query_idx2,
    output logic                 query_rdy1,
    output logic                 query_rdy2,
    output logic [31:0]          query_val1,
    output logic [31:0]          query_val2,
    output logic                 rf_update_en,
    output logic [4:0]           rf_update_reg,
    output logic [ROB_WIDTH-1:0] rf_update_index,
    output logic [31:0]          rf_update_data,
    output logic                 store_commit_en,
    output logic [ROB_WIDTH-1:0] store_commit_index,
    output logic                 flush_out,
    output logic [31:0]          flush_pc,
    output logic                 exit_out
);
    localparam int ROB_SIZE = 1 << ROB_WIDTH;

    logic [ROB_WIDTH-1:0] head;
    logic [ROB_WIDTH-1:0] tail;
    logic [ROB_WIDTH:0]   count;

    logic        head_ready;
    rob_info_t   head_info;
    rob_result_t head_res;
    rob_info_t   alloc_info;
    rob_result_t cdb_res;
    logic        commit;
    logic        mispredict;
    logic        alloc_ok;

    assign full        = (count == (ROB_WIDTH + 1)'(ROB_SIZE));
    assign alloc_index = tail;

    // Commit stalls during the flush pulse and permanently once EXIT has retired.
    assign commit     = (count != '0) && head_ready && !flush_out && !exit_out;
    assign mispredict = commit && (head_info.typ == TYPE_BRANCH) &&
                        (head_res.taken != head_info.pred_taken);
    // An allocation racing a mispredict commit would land in a buffer that is being wiped.
    assign alloc_ok   = alloc_en && !full && !flush_out && !mispredict;

    assign alloc_info = '{typ: rob_type_e'(alloc_type), rd: alloc_rd, pc: alloc_pc,
                          pred_taken: alloc_pred_taken};
    assign cdb_res    = '{value: cdb_value, taken: cdb_taken, target: cdb_target};

    rob_entry_array #(
        .ROB_WIDTH (ROB_WIDTH)
    ) u_entries (
        .clk        (clk_in),
        .rst        (rst_in),
        .alloc_we   (rdy_in && alloc_ok),
        .alloc_idx  (tail),
        .alloc_info (alloc_info),
        .cdb_we     (rdy_in && cdb_en),
        .cdb_idx    (cdb_index),
        .cdb_res    (cdb_res),
        .commit_clr (rdy_in && commit),
        .commit_idx (head),
        .clear_all  (rdy_in && mispredict),
        .head_idx   (head),
        .head_ready (head_ready),
        .head_info  (head_info),
        .head_res   (head_res),
        .q1_idx     (query_idx1),
        .q1_rdy     (query_rdy1),
        .q1_val     (query_val1),
        .q2_idx     (query_idx2),
        .q2_rdy     (query_rdy2),
        .q2_val     (query_val2)
    );

    // Head/tail/count bookkeeping; pointers wrap naturally at ROB_WIDTH bits.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy_in) begin
            if (mispredict) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (commit) begin
                    head <= head + 1'b1;
                end
                if (alloc_ok) begin
                    tail <= tail + 1'b1;
                end
                if (alloc_ok && !commit) begin
                    count <= count + 1'b1;
                end else if (commit && !alloc_ok) begin
                    count <= count - 1'b1;
                end
            end
        end
    end

    // Registered commit side effects: RF write, store release, flush redirect and sticky exit.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rf_update_en       <= 1'b0;
            rf_update_reg      <= '0;
            rf_update_index    <= '0;
            rf_update_data     <= '0;
            store_commit_en    <= 1'b0;
            store_commit_index <= '0;
            flush_out          <= 1'b0;
            flush_pc           <= '0;
            exit_out           <= 1'b0;
        end else if (rdy_in) begin
            rf_update_en    <= commit && (head_info.typ == TYPE_REG);
            store_commit_en <= commit && (head_info.typ == TYPE_STORE);
            flush_out       <= mispredict;
            if (commit && (head_info.typ == TYPE_REG)) begin
                rf_update_reg   <= head_info.rd;
                rf_update_index <= head;
                rf_update_data  <= head_res.value;
            end
            if (commit && (head_info.typ == TYPE_STORE)) begin
                store_commit_index <= head;
            end
            if (mispredict) begin
                flush_pc <= redirect_pc(head_info, head_res);
            end
            if (commit && (head_info.typ == TYPE_EXIT)) begin
                exit_out <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer with a queue-based reference model checked every cycle.
// Latency: model tracks registered outputs one edge after the causing inputs.
// Backpressure: exercises full, flush and rdy_in freeze paths.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        alloc_en;
    logic [1:0]  alloc_type;
    logic [4:0]  alloc_rd;
    logic [31:0] alloc_pc;
    logic        alloc_pred_taken;
    logic [2:0]  alloc_index;
    logic        full;
    logic        cdb_en;
    logic [2:0]  cdb_index;
    logic [31:0] cdb_value;
    logic        cdb_taken;
    logic [31:0] cdb_target;
    logic [2:0]  query_idx1;
    logic [2:0]  query_idx2;
    logic        query_rdy1;
    logic        query_rdy2;
    logic [31:0] query_val1;
    logic [31:0] query_val2;
    logic        rf_update_en;
    logic [4:0]  rf_update_reg;
    logic [2:0]  rf_update_index;
    logic [31:0] rf_update_data;
    logic        store_commit_en;
    logic [2:0]  store_commit_index;
    logic        flush_out;
    logic [31:0] flush_pc;
    logic        exit_out;

    int total_cnt = 0;
    int pass_cnt  = 0;
    bit chk_on    = 0;

    reorder_buffer #(.ROB_WIDTH(3)) dut (
        .clk_in             (clk),
        .rst_in             (rst),
        .rdy_in             (rdy),
        .alloc_en           (alloc_en),
        .alloc_type         (alloc_type),
        .alloc_rd           (alloc_rd),
        .alloc_pc           (alloc_pc),
        .alloc_pred_taken   (alloc_pred_taken),
        .alloc_index        (alloc_index),
        .full               (full),
        .cdb_en             (cdb_en),
        .cdb_index          (cdb_index),
        .cdb_value          (cdb_value),
        .cdb_taken          (cdb_taken),
        .cdb_target         (cdb_target),
        .query_idx1         (query_idx1),
        .query_idx2         (query_idx2),
        .query_rdy1         (query_rdy1),
        .query_rdy2         (query_rdy2),
        .query_val1         (query_val1),
        .query_val2         (query_val2),
        .rf_update_en       (rf_update_en),
        .rf_update_reg      (rf_update_reg),
        .rf_update_index    (rf_update_index),
        .rf_update_data     (rf_update_data),
        .store_commit_en    (store_commit_en),
        .store_commit_index (store_commit_index),
        .flush_out          (flush_out),
        .flush_pc           (flush_pc),
        .exit_out           (exit_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running, want finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: program-order list of live tags plus per-tag contents.
    int          live_q [$];
    int          m_tail;
    bit          m_busy  [8];
    bit          m_ready [8];
    logic [1:0]  m_type  [8];
    logic [4:0]  m_rd    [8];
    logic [31:0] m_pc    [8];
    bit          m_pred  [8];
    logic [31:0] m_val   [8];
    bit          m_taken [8];
    logic [31:0] m_tgt   [8];
    bit          e_rf_en, e_st_en, e_fl, e_exit;
    int          e_rf_idx, e_st_idx;
    logic [4:0]  e_rf_reg;
    logic [31:0] e_rf_dat, e_fl_pc;

    task automatic model_clear();
        live_q.delete();
        m_tail = 0;
        for (int i = 0; i < 8; i++) begin
            m_busy[i]  = 0;
            m_ready[i] = 0;
        end
    endtask

    task automatic model_step();
        bit was_full, in_flush, do_commit, wiped;
        int h;
        if (rst) begin
            model_clear();
            e_rf_en = 0; e_st_en = 0; e_fl = 0; e_exit = 0;
            e_rf_idx = 0; e_st_idx = 0; e_rf_reg = 0; e_rf_dat = 0; e_fl_pc = 0;
        end else if (rdy) begin
            was_full  = (live_q.size() == 8);
            in_flush  = e_fl;
            do_commit = (live_q.size() > 0) && m_ready[live_q[0]] && !in_flush && !e_exit;
            wiped     = 0;
            e_rf_en = 0; e_st_en = 0; e_fl = 0;
            if (cdb_en && m_busy[cdb_index]) begin
                m_ready[cdb_index] = 1;
                m_val[cdb_index]   = cdb_value;
                m_taken[cdb_index] = cdb_taken;
                m_tgt[cdb_index]   = cdb_target;
            end
            if (do_commit) begin
                h = live_q.pop_front();
                m_busy[h] = 0;
                m_ready[h] = 0;
                case (m_type[h])
                    2'b00: begin e_rf_en = 1; e_rf_reg = m_rd[h]; e_rf_idx = h; e_rf_dat = m_val[h]; end
                    2'b10: begin e_st_en = 1; e_st_idx = h; end
                    2'b01: if (m_taken[h] != m_pred[h]) begin
                        e_fl = 1;
                        e_fl_pc = m_taken[h] ? m_tgt[h] : m_pc[h] + 4;
                        wiped = 1;
                    end
                    default: e_exit = 1;
                endcase
            end
            if (wiped) begin
                model_clear();
            end else if (alloc_en && !was_full && !in_flush) begin
                live_q.push_back(m_tail);
                m_busy[m_tail]  = 1;
                m_ready[m_tail] = (alloc_type == 2'b10) || (alloc_type == 2'b11);
                m_type[m_tail]  = alloc_type;
                m_rd[m_tail]    = alloc_rd;
                m_pc[m_tail]    = alloc_pc;
                m_pred[m_tail]  = alloc_pred_taken;
                m_tail = (m_tail + 1) % 8;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                chk("full", full, live_q.size() == 8);
                chk("alloc_index", alloc_index, m_tail);
                chk("rf_update_en", rf_update_en, e_rf_en);
                chk("store_commit_en", store_commit_en, e_st_en);
                chk("flush_out", flush_out, e_fl);
                chk("exit_out", exit_out, e_exit);
                if (e_rf_en) begin
                    chk("rf_update_reg", rf_update_reg, e_rf_reg);
                    chk("rf_update_index", rf_update_index, e_rf_idx);
                    chk("rf_update_data", rf_update_data, e_rf_dat);
                end
                if (e_st_en) chk("store_commit_index", store_commit_index, e_st_idx);
                if (e_fl) chk("flush_pc", flush_pc, e_fl_pc);
                chk("query_rdy1", query_rdy1, m_busy[query_idx1] && m_ready[query_idx1]);
                chk("query_rdy2", query_rdy2, m_busy[query_idx2] && m_ready[query_idx2]);
                if (m_busy[query_idx1] && m_ready[query_idx1]) chk("query_val1", query_val1, m_val[query_idx1]);
                if (m_busy[query_idx2] && m_ready[query_idx2]) chk("query_val2", query_val2, m_val[query_idx2]);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic alloc(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] pc, input logic pred);
        alloc_en = 1; alloc_type = t; alloc_rd = rd; alloc_pc = pc; alloc_pred_taken = pred;
    endtask

    task automatic cdb(input logic [2:0] idx, input logic [31:0] val, input logic tk, input logic [31:0] tgt);
        cdb_en = 1; cdb_index = idx; cdb_value = val; cdb_taken = tk; cdb_target = tgt;
    endtask

    task automatic do_reset();
        rst = 1;
        cyc();
        rst = 0;
    endtask

    initial begin
        rst = 1; rdy = 1;
        alloc_en = 0; alloc_type = 0; alloc_rd = 0; alloc_pc = 0; alloc_pred_taken = 0;
        cdb_en = 0; cdb_index = 0; cdb_value = 0; cdb_taken = 0; cdb_target = 0;
        query_idx1 = 0; query_idx2 = 0;
        cyc();
        chk_on = 1;
        chk("rst_rf_en", rf_update_en, 0);
        chk("rst_flush", flush_out, 0);
        chk("rst_exit", exit_out, 0);
        chk("rst_full", full, 0);
        chk("rst_alloc_index", alloc_index, 0);
        rst = 0;

        // Single REG instruction: result commits two edges after the CDB.
        alloc(2'b00, 5'd5, 32'h1000, 0); cyc();
        alloc_en = 0; cdb(3'd0, 32'h1234, 0, 0); cyc();
        cdb_en = 0; cyc();
        chk("s1_rf_en", rf_update_en, 1);
        chk("s1_rf_reg", rf_update_reg, 5);
        chk("s1_rf_index", rf_update_index, 0);
        chk("s1_rf_data", rf_update_data, 32'h1234);
        chk("s1_alloc_index", alloc_index, 1);
        chk("s1_full", full, 0);
        rdy = 0; cyc();
        chk("s1_hold_rf_en", rf_update_en, 1);
        rdy = 1; cyc();
        chk("s1_rf_en_drop", rf_update_en, 0);

        // Fill, refuse the ninth, commit while full, then wrap the tail to tag 0.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            alloc(2'b00, 5'(i + 1), 32'h2000 + 32'(4 * i), 0); cyc();
        end
        chk("s2_full", full, 1);
        chk("s2_alloc_index", alloc_index, 0);
        alloc(2'b00, 5'd31, 32'h3000, 0); cyc();
        chk("s2_ninth_full", full, 1);
        chk("s2_ninth_index", alloc_index, 0);
        alloc_en = 0; cdb(3'd0, 32'hA0, 0, 0); cyc();
        cdb_en = 0; alloc(2'b00, 5'd9, 32'h3004, 0); cyc();
        chk("s2_commit_rf_en", rf_update_en, 1);
        chk("s2_commit_index", rf_update_index, 0);
        chk("s2_refused_full", full, 0);
        chk("s2_refused_index", alloc_index, 0);
        cyc();
        chk("s2_wrap_index", alloc_index, 1);
        chk("s2_wrap_full", full, 1);
        alloc_en = 0;

        // Out-of-order completion retires in program order.
        do_reset();
        alloc(2'b00, 5'd3, 32'h400, 0); cyc();
        alloc(2'b00, 5'd4, 32'h404, 0); cyc();
        alloc_en = 0; cdb(3'd1, 32'h11, 0, 0); cyc();
        cdb_en = 0; cyc();
        chk("s3_no_commit", rf_update_en, 0);
        cdb(3'd0, 32'h10, 0, 0); cyc();
        cdb_en = 0; cyc();
        chk("s3_c0_en", rf_update_en, 1);
        chk("s3_c0_index", rf_update_index, 0);
        chk("s3_c0_data", rf_update_data, 32'h10);
        cyc();
        chk("s3_c1_index", rf_update_index, 1);
        chk("s3_c1_data", rf_update_data, 32'h11);
        cyc();
        chk("s3_idle", rf_update_en, 0);

        // Mispredicted branch at tag 2 with two younger entries: flush to the taken target.
        alloc(2'b01, 5'd0, 32'h100, 0); cyc();
        alloc(2'b00, 5'd6, 32'h104, 0); cyc();
        alloc(2'b00, 5'd7, 32'h108, 0); cyc();
        alloc_en = 0; cdb(3'd2, 32'h0, 1, 32'h200); cyc();
        cdb_en = 0; alloc(2'b00, 5'd8, 32'h10C, 0); cyc();
        chk("s4_flush", flush_out, 1);
        chk("s4_flush_pc", flush_pc, 32'h200);
        chk("s4_alloc_index", alloc_index, 0);
        cyc();
        chk("s4_flush_drop", flush_out, 0);
        chk("s4_post_index", alloc_index, 0);
        chk("s4_post_full", full, 0);
        alloc_en = 0; query_idx1 = 3'd3; #1;
        chk("s4_query_cleared", query_rdy1, 0);

        // Bypass query, store release at tag 2, then EXIT stops retirement.
        alloc(2'b00, 5'd1, 32'h300, 0); cyc();
        alloc(2'b00, 5'd2, 32'h304, 0); cyc();
        alloc(2'b10, 5'd0, 32'h308, 0); cyc();
        alloc(2'b00, 5'd7, 32'h30C, 0); cyc();
        alloc(2'b11, 5'd0, 32'h310, 0); cyc();
        alloc_en = 0; cdb(3'd3, 32'hCAFE, 0, 0); query_idx1 = 3'd3; query_idx2 = 3'd5; cyc();
        chk("s6_query_rdy1", query_rdy1, 1);
        chk("s6_query_val1", query_val1, 32'hCAFE);
        chk("s6_query_rdy2", query_rdy2, 0);
        cdb(3'd0, 32'h50, 0, 0); cyc();
        cdb(3'd1, 32'h51, 0, 0); cyc();
        chk("s5_c0_data", rf_update_data, 32'h50);
        cdb_en = 0; cyc();
        chk("s5_c1_index", rf_update_index, 1);
        cyc();
        chk("s5_store_en", store_commit_en, 1);
        chk("s5_store_index", store_commit_index, 2);
        chk("s5_store_no_rf", rf_update_en, 0);
        cyc();
        chk("s5_c3_reg", rf_update_reg, 7);
        chk("s5_c3_data", rf_update_data, 32'hCAFE);
        chk("s5_store_drop", store_commit_en, 0);
        cyc();
        chk("s5_exit", exit_out, 1);
        alloc(2'b00, 5'd9, 32'h314, 0); cyc();
        alloc_en = 0; cdb(3'd5, 32'h77, 0, 0); cyc();
        cdb_en = 0; cyc(); cyc();
        chk("s5_exit_sticky", exit_out, 1);
        chk("s5_no_commit_after_exit", rf_update_en, 0);

        // Reset mid-operation clears the sticky exit and the occupancy.
        do_reset();
        chk("end_rst_exit", exit_out, 0);
        chk("end_rst_full", full, 0);
        cyc();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
